load_byte_assembler: RTL and testbench
======================================

# load_byte_assembler

Load unit between the 8-bit data-memory bus and the register file's write port. It accepts one load request per instruction (LB/LH/LW/LBU/LHU) and fetches 1, 2 or 4 bytes sequentially over the byte-wide handshake bus. It assembles the bytes little-endian, sign- or zero-extends the result, and presents a 32-bit word with a one-cycle `wb_load` strobe that drives the destination register's `data_in`/`load` inputs.

## Interface
- `ADDR_W`, 32: width of byte addresses.
- `clk`  in  1: clock; all state updates on rising edge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: request strobe; sampled only when `busy`=0.
- `funct3`  in  3: load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
- `addr`  in  ADDR_W: byte address of the load.
- `rd`  in  5: destination register index.
- `busy`  out  1: high whenever state is not IDLE.
- `mem_req`  out  1: byte-read request.
- `mem_addr`  out  ADDR_W: byte address of the current read.
- `mem_ack`  in  1: memory has valid `mem_rdata` this cycle.
- `mem_rdata`  in  8: read byte.
- `wb_load`  out  1: one-cycle write strobe to the register file.
- `wb_rd`  out  5: destination index, valid with `wb_load`.
- `wb_data`  out  32: extended load result, valid with `wb_load`.
- `err`  out  1: one-cycle pulse for a misaligned or illegal request.

## Operation
- States: IDLE, FETCH, WB, ERR. All outputs are registered or decoded from registered state only.
- Reset values: state IDLE, `busy`=0, `mem_req`=0, `mem_addr`=0, `wb_load`=0, `wb_rd`=0, `wb_data`=0, `err`=0. The byte counter and assembly buffer are cleared.
- IDLE, `start`=1:
  - Latch `addr`, `funct3` and `rd`.
  - Clear the assembly buffer and set byte count k=0.
  - Set N = 1 (LB/LBU), 2 (LH/LHU) or 4 (LW).
  - Go to FETCH. Go to ERR instead if `funct3` is illegal, if LH/LHU has `addr[0]`=1, or if LW has `addr[1:0]`≠0.
- FETCH:
  - `mem_req`=1 and `mem_addr`=base+k.
  - On each rising edge with `mem_ack`=1, write `mem_rdata` into buffer bits [8k+7:8k] and increment k.
  - `mem_req` stays high across bytes with no idle gap.
  - When the ack for byte N-1 is taken, go to WB.
- WB:
  - `wb_load`=1 for exactly one cycle, `wb_rd`=latched rd.
  - `wb_data`: LB = sign-extend bits [7:0]; LBU = zero-extend [7:0]; LH = sign-extend [15:0]; LHU = zero-extend [15:0]; LW = [31:0].
  - Then go to IDLE.
  - If rd=0, the memory access still runs but `wb_load` stays 0 (x0 is never written). `wb_data` is still updated.
- ERR: `err`=1 for one cycle, no memory traffic, no write-back, then IDLE.
- `start` while `busy`=1 is ignored. No request is queued.
- `wb_data` and `wb_rd` hold their last values after WB until the next WB.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- The register file samples `data_in`/`load` on the falling clock edge. `wb_data`, `wb_rd` and `wb_load` therefore change only on rising edges and are stable for the whole WB cycle.
- Zero-wait memory (`mem_ack` high every cycle), `start` sampled at edge 0:
  - FETCH covers cycles 1..N.
  - WB is cycle N+1.
  - `busy`=0 in cycle N+2, where the next `start` is accepted.
  - Latency to `wb_load` is N+1 cycles: LB 2, LH 3, LW 5.
- Each wait cycle (`mem_ack`=0 during FETCH) adds exactly one cycle; `mem_addr` holds.
- Error path: `err` is high in cycle 1, `busy`=0 in cycle 2.
- Synchronous reset mid-operation (any state):
  - Next cycle is IDLE with `mem_req`=0 and `wb_load`=0.
  - The partial buffer is discarded and never written back.
  - An ack arriving in that cycle is ignored.

## Test plan
- LW, addr 0x100, zero-wait bytes 0x78,0x56,0x34,0x12 -> `mem_addr` 0x100..0x103 in cycles 1-4; cycle 5 `wb_load`=1, `wb_data`=0x12345678, `wb_rd`=latched rd; `busy`=0 in cycle 6.
- LB addr 0x203 byte 0x80 -> `wb_data`=0xFFFFFF80. LBU, same byte -> 0x00000080. LH addr 0x10 bytes 0x34,0xF2 -> 0xFFFFF234. LHU, same bytes -> 0x0000F234.
- LW with 2 wait cycles before byte 1 and 1 before byte 3 -> `mem_addr` holds during waits; `wb_load` in cycle 8; data correct.
- LW addr 0x102, LH addr 0x101, funct3=011 -> each gives `err`=1 for one cycle, `mem_req` never asserted, `wb_load` never asserted.
- LW with rd=0 -> 4 memory reads occur, `wb_load` stays 0. `start` pulsed during FETCH -> ignored, exactly one transaction occurs.
- `reset_n`=0 in cycle 3 of an LW -> IDLE next cycle, `mem_req`=0, all outputs at reset values, no `wb_load`. A following LB completes normally.

Source files
------------

// File: rtl/load_byte_assembler.sv
// Byte-serial load unit: it fetches 1/2/4 bytes over an 8-bit handshake bus, assembles them
// little-endian and presents a sign- or zero-extended word with a one-cycle write-back strobe.
module load_byte_assembler #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [4:0]        rd,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              wb_load,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WB    = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [2:0]        funct3_r;
  logic [4:0]        rd_r;
  logic [31:0]       asm_r;
  logic [1:0]        k_r;
  logic [1:0]        last_r;
  logic [31:0]       merged_s;

  function automatic logic req_legal(input logic [2:0] f3, input logic [1:0] a_lo);
    case (f3)
      3'b000, 3'b100: req_legal = 1'b1;
      3'b001, 3'b101: req_legal = (a_lo[0] == 1'b0);
      3'b010:         req_legal = (a_lo == 2'b00);
      default:        req_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] last_index(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: last_index = 2'd0;
      3'b001, 3'b101: last_index = 2'd1;
      default:        last_index = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend_load = {{24{d[7]}}, d[7:0]};
      3'b100:  extend_load = {24'd0, d[7:0]};
      3'b001:  extend_load = {{16{d[15]}}, d[15:0]};
      3'b101:  extend_load = {16'd0, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

  // Assembly buffer with the byte arriving this cycle merged into lane k.
  always_comb begin
    merged_s = asm_r;
    case (k_r)
      2'd0:    merged_s[7:0]   = mem_rdata;
      2'd1:    merged_s[15:8]  = mem_rdata;
      2'd2:    merged_s[23:16] = mem_rdata;
      2'd3:    merged_s[31:24] = mem_rdata;
      default: merged_s = asm_r;
    endcase
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      base_r   <= {ADDR_W{1'b0}};
      funct3_r <= 3'd0;
      rd_r     <= 5'd0;
      asm_r    <= 32'd0;
      k_r      <= 2'd0;
      last_r   <= 2'd0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= {ADDR_W{1'b0}};
      wb_load  <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      err      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wb_load <= 1'b0;
          err     <= 1'b0;
          if (start) begin
            base_r   <= addr;
            funct3_r <= funct3;
            rd_r     <= rd;
            asm_r    <= 32'd0;
            k_r      <= 2'd0;
            last_r   <= last_index(funct3);
            busy     <= 1'b1;
            if (req_legal(funct3, addr[1:0])) begin
              state_r  <= FETCH;
              mem_req  <= 1'b1;
              mem_addr <= addr;
            end else begin
              state_r <= ERR;
              err     <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            asm_r <= merged_s;
            k_r   <= k_r + 2'd1;
            if (k_r == last_r) begin
              // Final byte: leave the bus and publish the extended word in one step.
              state_r <= WB;
              mem_req <= 1'b0;
              wb_load <= (rd_r != 5'd0);
              wb_rd   <= rd_r;
              wb_data <= extend_load(funct3_r, merged_s);
            end else begin
              mem_addr <= base_r + {{(ADDR_W-2){1'b0}}, k_r} + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            mem_addr <= mem_addr;
          end
        end
        WB: begin
          state_r <= IDLE;
          wb_load <= 1'b0;
          busy    <= 1'b0;
        end
        ERR: begin
          state_r <= IDLE;
          err     <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          wb_load <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_byte_assembler.sv
// Directed self-checking bench for load_byte_assembler with hand-computed expectations.
module tb_load_byte_assembler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        wb_load;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int total = 0;
  int passed = 0;

  load_byte_assembler #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3), .addr(addr), .rd(rd),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " wb_load"}, 32'(wb_load), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
  endtask

  // waits holds a 4-bit wait-cycle count per byte; poke pulses start mid-fetch.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] r, input logic [31:0] bytes, input int n,
                         input logic [15:0] waits, input bit poke, input logic [31:0] exp);
    start = 1'b1; funct3 = f3; addr = a; rd = r;
    tick();
    start = 1'b0; funct3 = 3'd0; addr = 32'd0; rd = 5'd0;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < int'(waits[4*i +: 4]); w++) begin
        mem_ack = 1'b0;
        check({tag, " wait mem_req"}, 32'(mem_req), 32'd1);
        check({tag, " wait mem_addr"}, mem_addr, a + 32'(i));
        tick();
      end
      mem_ack = 1'b1;
      mem_rdata = bytes[8*i +: 8];
      check({tag, " mem_req"}, 32'(mem_req), 32'd1);
      check({tag, " mem_addr"}, mem_addr, a + 32'(i));
      check({tag, " fetch busy"}, 32'(busy), 32'd1);
      check({tag, " early wb_load"}, 32'(wb_load), 32'd0);
      if (poke && i == 1) begin
        start = 1'b1; funct3 = 3'b000; addr = 32'h500; rd = 5'd9;
      end
      tick();
      start = 1'b0;
    end
    mem_ack = 1'b0;
    check({tag, " wb_load"}, 32'(wb_load), (r != 5'd0) ? 32'd1 : 32'd0);
    check({tag, " wb_data"}, wb_data, exp);
    check({tag, " wb_rd"}, 32'(wb_rd), 32'(r));
    check({tag, " wb busy"}, 32'(busy), 32'd1);
    check({tag, " wb mem_req"}, 32'(mem_req), 32'd0);
    tick();
    check_idle({tag, " after"});
    check({tag, " wb_data hold"}, wb_data, exp);
    if (poke) begin
      tick();
      check_idle({tag, " no queued"});
    end
  endtask

  task automatic do_err(input string tag, input logic [2:0] f3, input logic [31:0] a);
    start = 1'b1; funct3 = f3; addr = a; rd = 5'd3;
    mem_ack = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " err"}, 32'(err), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " wb_load"}, 32'(wb_load), 32'd0);
    tick();
    mem_ack = 1'b0;
    check_idle({tag, " after"});
  endtask

  initial begin
    reset_n = 1'b0;
    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst wb_load", 32'(wb_load), 32'd0);
    check("rst wb_rd", 32'(wb_rd), 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick();

    do_load("lw", 3'b010, 32'h100, 5'd7, 32'h12345678, 4, 16'h0000, 1'b0, 32'h12345678);
    do_load("lb", 3'b000, 32'h203, 5'd1, 32'h00000080, 1, 16'h0000, 1'b0, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h203, 5'd2, 32'h00000080, 1, 16'h0000, 1'b0, 32'h00000080);
    do_load("lh", 3'b001, 32'h10, 5'd3, 32'h0000F234, 2, 16'h0000, 1'b0, 32'hFFFFF234);
    do_load("lhu", 3'b101, 32'h10, 5'd4, 32'h0000F234, 2, 16'h0000, 1'b0, 32'h0000F234);
    do_load("lb pos", 3'b000, 32'h41, 5'd5, 32'h0000007F, 1, 16'h0000, 1'b0, 32'h0000007F);
    do_load("lw wait", 3'b010, 32'h300, 5'd6, 32'hCAFEBABE, 4, 16'h1020, 1'b0, 32'hCAFEBABE);
    do_load("lw rd0", 3'b010, 32'h400, 5'd0, 32'hA1B2C3D4, 4, 16'h0000, 1'b1, 32'hA1B2C3D4);

    do_err("lw mis", 3'b010, 32'h102);
    do_err("lh mis", 3'b001, 32'h101);
    do_err("illegal", 3'b011, 32'h100);

    // Reset in cycle 3 of an LW, with an ack present in the following cycle.
    start = 1'b1; funct3 = 3'b010; addr = 32'h600; rd = 5'd8;
    tick();
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_rdata = 8'h22;
    tick();
    check("mid mem_addr", mem_addr, 32'h602);
    reset_n = 1'b0; mem_rdata = 8'h33;
    tick();
    reset_n = 1'b1;
    check("srst busy", 32'(busy), 32'd0);
    check("srst mem_req", 32'(mem_req), 32'd0);
    check("srst mem_addr", mem_addr, 32'd0);
    check("srst wb_load", 32'(wb_load), 32'd0);
    check("srst wb_rd", 32'(wb_rd), 32'd0);
    check("srst wb_data", wb_data, 32'd0);
    check("srst err", 32'(err), 32'd0);
    tick();
    mem_ack = 1'b0;
    check_idle("srst ack ignored");
    do_load("lb post", 3'b000, 32'h700, 5'd9, 32'h000000C3, 1, 16'h0000, 1'b0, 32'hFFFFFFC3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
